// File: rtl/mem_wb_writeback.sv
// MEM/WB stage of the RV32I core: registers the MEM result, formats load data
// from the synchronous DM, drives the register-file write port, counts retires.
module mem_wb_writeback #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic             m_reg_write,
    input  logic             m_mem_to_reg,
    input  logic [4:0]       m_rd,
    input  logic [2:0]       m_funct3,
    input  logic [31:0]      m_alu_result,
    input  logic [31:0]      dm_rdata,
    output logic             wb_en,
    output logic [4:0]       wb_addr,
    output logic [31:0]      write_data,
    output logic [CNT_W-1:0] retire_cnt
);

    logic        valid_q;
    logic        reg_write_q;
    logic        mem_to_reg_q;
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [31:0] alu_q;
    logic [31:0] rdata_hold;
    logic        held;
    logic        fire;
    logic [31:0] ld_src;
    logic [31:0] ld_fmt;
    logic [1:0]  a;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            rd_q         <= '0;
            funct3_q     <= '0;
            alu_q        <= '0;
        end else if (!stall) begin
            valid_q      <= m_valid & ~flush;
            reg_write_q  <= m_reg_write;
            mem_to_reg_q <= m_mem_to_reg;
            rd_q         <= m_rd;
            funct3_q     <= m_funct3;
            alu_q        <= m_alu_result;
        end
    end

    // DM data is only valid in the first WB cycle; keep it across a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_hold <= '0;
            held       <= 1'b0;
        end else if (!stall) begin
            held <= 1'b0;
        end else if (valid_q && mem_to_reg_q && !held) begin
            rdata_hold <= dm_rdata;
            held       <= 1'b1;
        end
    end

    assign fire   = valid_q & ~stall;
    assign ld_src = held ? rdata_hold : dm_rdata;

    always_comb begin
        a       = alu_q[1:0];
        ld_byte = ld_src[{a, 3'b000} +: 8];
        ld_half = a[1] ? ld_src[31:16] : ld_src[15:0];
        ld_fmt  = ld_src;
        case (funct3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = ld_src;
        endcase
    end

    assign write_data = mem_to_reg_q ? ld_fmt : alu_q;
    assign wb_addr    = rd_q;
    assign wb_en      = fire & reg_write_q & (rd_q != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            retire_cnt <= '0;
        else if (fire)
            retire_cnt <= retire_cnt + CNT_W'(1);
    end

endmodule
